seq_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector; successor to the fixed 4-bit Moore "1001" detector.
- Pattern, pattern length and overlap mode are runtime-configurable up to MAX_LEN bits.
- Adds an input-valid qualifier, a saturating match counter and a fill-level observation port.
- Sits on a serial bit stream. Typical use: frame/sync-word detection ahead of a deserialiser.

---
 rtl/seq_det_pkg.sv | 37 +++
 rtl/seq_detector_param_sat_counter.sv | 32 +++
 rtl/seq_detector_param.sv | 126 ++++++++++++
 tb/tb_seq_detector_param.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared constants and helpers for the parametrised serial
//               bit-pattern detector (width helper, reset defaults, length
//               clamp).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Reset-time configuration of the detector: the classic "1001" Moore
    // detector, overlapping matches allowed.
    localparam int unsigned c_default_max_len = 8;
    localparam logic [7:0]  c_default_pattern = 8'b0000_1001;
    localparam int unsigned c_default_len     = 4;
    localparam bit          c_default_overlap = 1'b1;

    // Width of a field that must hold every value 0..max_len inclusive.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // A zero length would make every bit a match of nothing, so it is
    // promoted to 1; anything longer than the history is cut to max_len.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping, with
//               synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Clear wins over increment; the increment is suppressed once saturated.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Runtime-configurable serial pattern detector with input-valid
//               qualifier, optional overlap, saturating match counter and
//               history fill-level observation port.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN         = c_default_max_len,
    parameter int unsigned          CNT_W           = 8,
    parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(c_default_pattern),
    parameter int unsigned          DEFAULT_LEN     = c_default_len,
    parameter bit                   DEFAULT_OVERLAP = c_default_overlap
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_bit,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]    cfg_len,
    input  logic                         cfg_overlap,
    output logic                         z,
    output logic [CNT_W-1:0]             match_count,
    output logic [len_w(MAX_LEN)-1:0]    fill_out
);

    localparam int unsigned          c_len_w     = len_w(MAX_LEN);
    localparam logic [c_len_w-1:0]   c_reset_len = c_len_w'(clamp_len(DEFAULT_LEN, MAX_LEN));

    // Active configuration
    logic [MAX_LEN-1:0] r_pattern;
    logic [c_len_w-1:0] r_len;
    logic               r_overlap;

    // Detection state
    logic [MAX_LEN-1:0] r_hist;
    logic [c_len_w-1:0] r_fill;
    logic               r_z;

    logic [MAX_LEN-1:0] w_hist_next;
    logic [MAX_LEN-1:0] w_len_mask;
    logic [c_len_w-1:0] w_cfg_len;
    logic [c_len_w-1:0] w_fill_next;
    logic               w_accept;
    logic               w_fill_ok;
    logic               w_match;
    logic               w_unused_hist_msb;

    // A bit presented alongside cfg_load is dropped.
    assign w_accept    = in_valid && !cfg_load;
    assign w_hist_next = {r_hist[MAX_LEN-2:0], in_bit};
    assign w_cfg_len   = c_len_w'(clamp_len(32'(cfg_len), MAX_LEN));

    // The oldest history bit only ever shifts out; it is never compared.
    assign w_unused_hist_msb = r_hist[MAX_LEN-1];

    // Select the low r_len history bits for comparison.
    always_comb begin
        w_len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            w_len_mask[i] = (i < 32'(r_len));
        end
    end

    // Enough valid bits once this one is included, and the low len bits agree.
    assign w_fill_ok = ({1'b0, r_fill} + (c_len_w + 1)'(1)) >= {1'b0, r_len};
    assign w_match   = w_accept && w_fill_ok
                       && (((w_hist_next ^ r_pattern) & w_len_mask) == '0);

    // Non-overlap restarts the fill count so no matched bit can be reused;
    // otherwise fill grows up to the pattern length and stays there.
    always_comb begin
        w_fill_next = r_fill;
        if (w_match && !r_overlap) begin
            w_fill_next = '0;
        end else if (r_fill < r_len) begin
            w_fill_next = r_fill + c_len_w'(1);
        end else begin
            w_fill_next = r_len;
        end
    end

    // Configuration and detection state; rst > cfg_load > in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= DEFAULT_PATTERN;
            r_len     <= c_reset_len;
            r_overlap <= DEFAULT_OVERLAP;
            r_hist    <= '0;
            r_fill    <= '0;
            r_z       <= 1'b0;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_cfg_len;
            r_overlap <= cfg_overlap;
            r_hist    <= '0;
            r_fill    <= '0;
            r_z       <= 1'b0;
        end else if (in_valid) begin
            r_hist    <= w_hist_next;
            r_fill    <= w_fill_next;
            r_z       <= w_match;
        end else begin
            r_z       <= 1'b0;
        end
    end

    sat_counter #(
        .W     (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cfg_load),
        .inc   (w_match),
        .count (match_count)
    );

    assign z        = r_z;
    assign fill_out = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Self-checking bench for seq_detector_param: directed vector
//               table plus randomised traffic against a queue-based model.
//               A second instance with a 2-bit counter shares the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_bit, cfg_load, cfg_overlap;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;

    logic       z, z_s;
    logic [7:0] match_count;
    logic [1:0] cnt_s;
    logic [3:0] fill_out, fill_s;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .z(z), .match_count(match_count),
        .fill_out(fill_out)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .z(z_s), .match_count(cnt_s),
        .fill_out(fill_s)
    );

    typedef struct {
        logic       r;
        logic       cl;
        logic       v;
        logic       b;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       ez;
        int         ec;
        int         ef;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the queue holds the usable history bits, oldest first.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_q[$];
    bit         m_z;
    int         m_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void add(input logic r, input logic cl, input logic v,
                                input logic b, input logic [7:0] pat,
                                input logic [3:0] len, input logic ovl,
                                input logic ez, input int ec, input int ef);
        vec_t t;
        t.r = r; t.cl = cl; t.v = v; t.b = b; t.pat = pat; t.len = len;
        t.ovl = ovl; t.ez = ez; t.ec = ec; t.ef = ef;
        vecs.push_back(t);
    endfunction

    function automatic void bitv(input logic b, input logic ez, input int ec, input int ef);
        add(1'b0, 1'b0, 1'b1, b, 8'h00, 4'd0, 1'b0, ez, ec, ef);
    endfunction

    function automatic void gap(input int ec, input int ef);
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, ec, ef);
    endfunction

    function automatic void cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        add(1'b0, 1'b1, 1'b0, 1'b0, pat, len, ovl, 1'b0, 0, 0);
    endfunction

    function automatic void model_step(input bit r, input bit cl, input bit v,
                                       input bit b, input logic [7:0] pat,
                                       input int len, input bit ovl);
        bit hit;
        if (r) begin
            m_pat = 8'b0000_1001; m_len = 4; m_ovl = 1'b1;
            m_q.delete(); m_z = 1'b0; m_cnt = 0;
        end else if (cl) begin
            m_pat = pat;
            m_len = (len == 0) ? 1 : ((len > 8) ? 8 : len);
            m_ovl = ovl;
            m_q.delete(); m_z = 1'b0; m_cnt = 0;
        end else if (v) begin
            m_q.push_back(b);
            hit = (m_q.size() >= m_len);
            for (int k = 0; k < m_len && hit; k++) begin
                if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
            end
            m_z = hit;
            if (hit) m_cnt++;
            if (hit && !m_ovl) m_q.delete();
            while (m_q.size() > m_len) void'(m_q.pop_front());
        end else begin
            m_z = 1'b0;
        end
    endfunction

    task automatic apply(input logic r, input logic cl, input logic v, input logic b,
                         input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        rst = r; cfg_load = cl; in_valid = v; in_bit = b;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

        // Reset, then default "1001" with overlap on 1000_1001_1001_1101.
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 0, 0);
        bitv(1,0,0,1); bitv(0,0,0,2); bitv(0,0,0,3); bitv(0,0,0,4);
        bitv(1,0,0,4); bitv(0,0,0,4); bitv(0,0,0,4); bitv(1,1,1,4);
        bitv(1,0,1,4); bitv(0,0,1,4); bitv(0,0,1,4); bitv(1,1,2,4);
        bitv(1,0,2,4); bitv(1,0,2,4); bitv(0,0,2,4); bitv(1,0,2,4);
        // Overlap on, stream 1001001.
        cfg(8'h09, 4'd4, 1'b1);
        bitv(1,0,0,1); bitv(0,0,0,2); bitv(0,0,0,3); bitv(1,1,1,4);
        bitv(0,0,1,4); bitv(0,0,1,4); bitv(1,1,2,4);
        // Overlap off, same stream.
        cfg(8'h09, 4'd4, 1'b0);
        bitv(1,0,0,1); bitv(0,0,0,2); bitv(0,0,0,3); bitv(1,1,1,0);
        bitv(0,0,1,1); bitv(0,0,1,2); bitv(1,0,1,3);
        // Pattern 101 with valid gaps.
        cfg(8'h05, 4'd3, 1'b1);
        bitv(1,0,0,1); gap(0,1); gap(0,1); bitv(0,0,0,2); gap(0,2);
        bitv(1,1,1,3); bitv(0,0,1,3); bitv(1,1,2,3); gap(2,3);
        // Single-bit pattern, ten matches back to back.
        cfg(8'h01, 4'd1, 1'b1);
        for (int k = 1; k <= 10; k++) bitv(1, 1, k, 1);
        // Reset after a partial "100".
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 0, 0);
        bitv(1,0,0,1); bitv(0,0,0,2); bitv(0,0,0,3);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 0, 0);
        bitv(1,0,0,1);
        // Length 0 behaves as length 1.
        cfg(8'h01, 4'd0, 1'b1);
        bitv(1,1,1,1); bitv(0,0,1,1);
        // Length 12 behaves as length 8 (pattern 1010_0101).
        cfg(8'hA5, 4'd12, 1'b1);
        bitv(1,0,0,1); bitv(0,0,0,2); bitv(1,0,0,3); bitv(0,0,0,4);
        bitv(0,0,0,5); bitv(1,0,0,6); bitv(0,0,0,7); bitv(1,1,1,8);
        // cfg_load with in_valid: the bit is dropped.
        add(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 0, 0);
        gap(0,0); bitv(1,1,1,1);
        // rst and cfg_load together: reset defaults win.
        add(1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 0, 0);
        bitv(1,0,0,1); bitv(0,0,0,2);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].cl, vecs[i].v, vecs[i].b,
                  vecs[i].pat, vecs[i].len, vecs[i].ovl);
            check($sformatf("vec%0d z", i), int'(z), int'(vecs[i].ez));
            check($sformatf("vec%0d count", i), int'(match_count), vecs[i].ec);
            check($sformatf("vec%0d fill", i), int'(fill_out), vecs[i].ef);
            check($sformatf("vec%0d sat_count", i), int'(cnt_s), min_i(vecs[i].ec, 3));
        end

        // Randomised traffic against the model, starting from reset.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic       r, cl, v, b, ovl;
            logic [7:0] pat;
            logic [3:0] len;
            r   = ($urandom_range(0, 99) == 0);
            cl  = ($urandom_range(0, 19) == 0);
            v   = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom_range(0, 1));
            pat = 8'($urandom);
            len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 4));
            ovl = 1'($urandom_range(0, 1));
            apply(r, cl, v, b, pat, len, ovl);
            model_step(r, cl, v, b, pat, int'(len), ovl);
            check($sformatf("rnd%0d z", i), int'(z), int'(m_z));
            check($sformatf("rnd%0d count", i), int'(match_count), min_i(m_cnt, 255));
            check($sformatf("rnd%0d fill", i), int'(fill_out), m_q.size());
            check($sformatf("rnd%0d sat_count", i), int'(cnt_s), min_i(m_cnt, 3));
            check($sformatf("rnd%0d sat_z", i), int'(z_s), int'(m_z));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
